// File: rtl/vm_canon_check.sv
// vm_canon_check: one-stage virtual-address canonicality checker for RV64 Sv39/Sv48/Sv57
// with pointer masking. Produces the masked/extended address and a fault flag per
// request, and keeps a sticky first-fault record and a saturating fault counter.

package cvw;
   typedef struct packed {
      int XLEN;
      int SVMODE_BITS;
   } cvw_t;

   localparam cvw_t CVW_DEFAULT = '{XLEN: 64, SVMODE_BITS: 4};
endpackage

module vm_canon_check
   import cvw::*;
#(
   parameter cvw_t P             = CVW_DEFAULT,
   parameter int   FAULTCNT_BITS = 16
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [P.SVMODE_BITS-1:0]   SATP_MODE,
   input  logic [1:0]                 PMLEN,
   input  logic                       InValid,
   output logic                       InReady,
   input  logic [P.XLEN-1:0]          VAdr,
   input  logic                       Flush,
   output logic                       OutValid,
   input  logic                       OutReady,
   output logic [P.XLEN-1:0]          OutVAdr,
   output logic                       UpperBitsUnequal,
   input  logic                       FaultCntClr,
   output logic [FAULTCNT_BITS-1:0]   FaultCnt,
   output logic                       FirstFaultValid,
   output logic [P.XLEN-1:0]          FirstFaultVAdr
);

   localparam int  XLEN   = P.XLEN;
   localparam int  MODE_W = P.SVMODE_BITS;
   localparam bit  CHK_EN = (XLEN == 64);

   logic [XLEN-1:0]          masked_c;
   logic                     fault_c;

   logic                     vld_q, vld_d;
   logic [XLEN-1:0]          vadr_q, vadr_d;
   logic                     fault_q, fault_d;
   logic [XLEN-1:0]          raw_q, raw_d;
   logic [FAULTCNT_BITS-1:0] cnt_q, cnt_d;
   logic                     ffv_q, ffv_d;
   logic [XLEN-1:0]          ffa_q, ffa_d;

   logic                     accept;
   logic                     xfer;

   // ---- input side: combinational mask and canonicality check (feeds the output register only)
   generate
      if (XLEN == 64) begin : g_check
         logic            is_sv39, is_sv48, is_sv57, is_sv;
         logic            pm7, pm16, sign_bit;
         logic [XLEN-1:0] top_mask;

         // Decode mode, replace the masked top field, then test bits above the VA width
         always_comb begin
            is_sv39  = (SATP_MODE == MODE_W'(8));
            is_sv48  = (SATP_MODE == MODE_W'(9));
            is_sv57  = (SATP_MODE == MODE_W'(10));
            is_sv    = is_sv39 | is_sv48 | is_sv57;
            // Sv57 leaves only 7 spare bits, so PMLEN16 shrinks to 7 there
            pm7      = (PMLEN == 2'b01) | ((PMLEN == 2'b10) & is_sv57);
            pm16     = (PMLEN == 2'b10) & ~is_sv57;
            top_mask = '0;
            sign_bit = 1'b0;
            if (pm7) begin
               top_mask = {{7{1'b1}}, {(XLEN-7){1'b0}}};
               sign_bit = VAdr[XLEN-8];
            end else if (pm16) begin
               top_mask = {{16{1'b1}}, {(XLEN-16){1'b0}}};
               sign_bit = VAdr[XLEN-17];
            end
            // Bare mode zero-fills the masked field instead of sign-extending
            if (!is_sv) sign_bit = 1'b0;
            masked_c = (VAdr & ~top_mask) | (top_mask & {XLEN{sign_bit}});
            fault_c  = 1'b0;
            if (is_sv39)
               fault_c = ~((&masked_c[XLEN-1:38]) | ~(|masked_c[XLEN-1:38]));
            else if (is_sv48)
               fault_c = ~((&masked_c[XLEN-1:47]) | ~(|masked_c[XLEN-1:47]));
            else if (is_sv57)
               fault_c = ~((&masked_c[XLEN-1:56]) | ~(|masked_c[XLEN-1:56]));
         end
      end else begin : g_bypass
         assign masked_c = VAdr;
         assign fault_c  = 1'b0;
      end
   endgenerate

   assign InReady = ~vld_q | OutReady;
   assign accept  = InValid & InReady;
   // A flushed entry is discarded, so it neither transfers nor counts
   assign xfer    = vld_q & OutReady & ~Flush;

   // Next-state for the output register, fault counter and first-fault record
   always_comb begin
      vld_d   = vld_q;
      vadr_d  = vadr_q;
      fault_d = fault_q;
      raw_d   = raw_q;
      cnt_d   = cnt_q;
      ffv_d   = ffv_q;
      ffa_d   = ffa_q;

      if (Flush) begin
         vld_d = 1'b0;
      end else if (accept) begin
         vld_d   = 1'b1;
         vadr_d  = masked_c;
         fault_d = fault_c;
         raw_d   = VAdr;
      end else if (xfer) begin
         vld_d = 1'b0;
      end

      // Clear has priority; a fault transferring in the clear cycle is lost on purpose
      if (FaultCntClr) begin
         cnt_d = '0;
         ffv_d = 1'b0;
         ffa_d = '0;
      end else if (CHK_EN && xfer && fault_q) begin
         if (!(&cnt_q)) cnt_d = cnt_q + FAULTCNT_BITS'(1);
         if (!ffv_q) begin
            ffv_d = 1'b1;
            ffa_d = raw_q;
         end
      end
   end

   // ---- output register stage
   // State registers with synchronous reset
   always_ff @(posedge clk) begin
      if (reset) begin
         vld_q   <= 1'b0;
         vadr_q  <= '0;
         fault_q <= 1'b0;
         raw_q   <= '0;
         cnt_q   <= '0;
         ffv_q   <= 1'b0;
         ffa_q   <= '0;
      end else begin
         vld_q   <= vld_d;
         vadr_q  <= vadr_d;
         fault_q <= fault_d;
         raw_q   <= raw_d;
         cnt_q   <= cnt_d;
         ffv_q   <= ffv_d;
         ffa_q   <= ffa_d;
      end
   end

   assign OutValid         = vld_q;
   assign OutVAdr          = vadr_q;
   assign UpperBitsUnequal = fault_q;
   assign FaultCnt         = cnt_q;
   assign FirstFaultValid  = ffv_q;
   assign FirstFaultVAdr   = ffa_q;

endmodule
